// File: rtl/cdb_arbiter_if.sv
// Common data bus arbiter interface: requester handshake plus the broadcast bus.
// master = requester/consumer side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 4,
  parameter int DATA_W  = 32
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic                      rdy;
  logic                      clear;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*TAG_W-1:0]  req_tag;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      cdb_valid;
  logic [TAG_W-1:0]          cdb_tag;
  logic [DATA_W-1:0]         cdb_data;
  logic [SRC_W-1:0]          cdb_src;

  modport master (
    output rdy, clear, req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );

  modport slave (
    input  rdy, clear, req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one holding slot per execution unit, one (tag, data)
// broadcast per cycle. Optional performance counters are built when the macro
// CDB_PERF_CNT_EN is defined (adds perf_busy / perf_conflict outputs).
module cdb_arbiter #(
  parameter int               NUM_REQ   = 4,
  parameter int               TAG_W     = 4,
  parameter int               DATA_W    = 32,
  parameter logic [TAG_W-1:0] EMPTY_TAG = '0
) (
  input  logic        clk,
  input  logic        rst,
`ifdef CDB_PERF_CNT_EN
  output logic [31:0] perf_busy,
  output logic [31:0] perf_conflict,
`endif
  cdb_arbiter_if.slave bus
);
  localparam int SRC_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             slot_valid;
  logic [NUM_REQ-1:0][TAG_W-1:0]  slot_tag;
  logic [NUM_REQ-1:0][DATA_W-1:0] slot_data;
  logic [SRC_W-1:0]               rr_ptr;

  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic [SRC_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] accept;

  logic               cdb_valid_q;
  logic [TAG_W-1:0]   cdb_tag_q;
  logic [DATA_W-1:0]  cdb_data_q;
  logic [SRC_W-1:0]   cdb_src_q;

  // Rotating-priority search over full slots, starting at rr_ptr; looks only at
  // slot state so the ready path never loops back through req_valid.
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    any_grant = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_grant && slot_valid[idx]) begin
        grant[idx] = 1'b1;
        any_grant  = 1'b1;
        win_idx    = SRC_W'(idx);
      end
    end
  end

  // A slot can take a new result when empty or when it is being drained now.
  assign bus.req_ready = {NUM_REQ{bus.rdy & ~rst & ~bus.clear}} & (~slot_valid | grant);
  assign accept        = bus.req_valid & bus.req_ready;

  // Slot fill/drain, broadcast registers and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid  <= '0;
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= EMPTY_TAG;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else if (bus.clear) begin
      slot_valid  <= '0;
      rr_ptr      <= '0;
      cdb_valid_q <= 1'b0;
    end else if (bus.rdy) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          // An EMPTY_TAG result is consumed but never occupies the slot.
          slot_valid[i] <= (bus.req_tag[i*TAG_W +: TAG_W] != EMPTY_TAG);
          slot_tag[i]   <= bus.req_tag[i*TAG_W +: TAG_W];
          slot_data[i]  <= bus.req_data[i*DATA_W +: DATA_W];
        end else if (grant[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      cdb_valid_q <= any_grant;
      if (any_grant) begin
        cdb_tag_q  <= slot_tag[win_idx];
        cdb_data_q <= slot_data[win_idx];
        cdb_src_q  <= win_idx;
        rr_ptr     <= (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;

`ifdef CDB_PERF_CNT_EN
  logic [31:0] busy_q;
  logic [31:0] conflict_q;

  // Utilisation counters: survive clear, freeze on stall, wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      conflict_q <= '0;
    end else if (bus.rdy) begin
      if (any_grant && !bus.clear) busy_q <= busy_q + 32'd1;
      if ($countones(slot_valid) > 1) conflict_q <= conflict_q + 32'd1;
    end
  end

  assign perf_busy     = busy_q;
  assign perf_conflict = conflict_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level model of the slots.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   tests_run;
  int   failed;

`ifdef CDB_PERF_CNT_EN
  logic [31:0] perf_busy;
  logic [31:0] perf_conflict;
`endif

  cdb_arbiter_if #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) bus ();

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW), .EMPTY_TAG(4'd0)) dut (
    .clk(clk),
    .rst(rst),
`ifdef CDB_PERF_CNT_EN
    .perf_busy(perf_busy),
    .perf_conflict(perf_conflict),
`endif
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: pending result per requester and the broadcast register.
  int          m_full[N];
  logic [3:0]  m_tag[N];
  logic [31:0] m_data[N];
  int          m_next;
  logic        m_cv;
  logic [3:0]  m_ct;
  logic [31:0] m_cd;
  int          m_cs;
  logic [31:0] m_busy;
  logic [31:0] m_conf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_winner();
    for (int k = 0; k < N; k++)
      if (m_full[(m_next + k) % N] != 0) return (m_next + k) % N;
    return -1;
  endfunction

  // One clock: check ready before the edge, advance the model, check outputs after.
  task automatic step();
    int         w;
    int         nfull;
    logic [3:0] exp_rdy;
    #1;
    w = m_winner();
    exp_rdy = '0;
    if (bus.rdy && !rst && !bus.clear)
      for (int i = 0; i < N; i++) exp_rdy[i] = (m_full[i] == 0) || (i == w);
    check("req_ready", bus.req_ready, exp_rdy);
    @(posedge clk);
    nfull = 0;
    for (int i = 0; i < N; i++) nfull += (m_full[i] != 0) ? 1 : 0;
    if (rst) begin
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_next = 0; m_cv = 0; m_ct = 0; m_cd = 0; m_cs = 0;
      m_busy = 0; m_conf = 0;
    end else if (bus.clear) begin
      for (int i = 0; i < N; i++) m_full[i] = 0;
      m_next = 0; m_cv = 0;
      if (bus.rdy && nfull >= 2) m_conf++;
    end else if (bus.rdy) begin
      if (nfull >= 2) m_conf++;
      if (w >= 0) begin
        m_cv = 1; m_ct = m_tag[w]; m_cd = m_data[w]; m_cs = w;
        m_full[w] = 0;
        m_next = (w + 1) % N;
        m_busy++;
      end else begin
        m_cv = 0;
      end
      for (int i = 0; i < N; i++)
        if (bus.req_valid[i] && exp_rdy[i]) begin
          m_tag[i]  = bus.req_tag[i*TW +: TW];
          m_data[i] = bus.req_data[i*DW +: DW];
          m_full[i] = (m_tag[i] != 4'd0) ? 1 : 0;
        end
    end
    #1;
    check("cdb_valid", bus.cdb_valid, m_cv);
    check("cdb_tag", bus.cdb_tag, m_ct);
    check("cdb_data", bus.cdb_data, m_cd);
    check("cdb_src", bus.cdb_src, m_cs[1:0]);
`ifdef CDB_PERF_CNT_EN
    check("perf_busy", perf_busy, m_busy);
    check("perf_conflict", perf_conflict, m_conf);
`endif
  endtask

  task automatic present(input int i, input logic [3:0] t, input logic [31:0] d);
    bus.req_valid[i]          = 1'b1;
    bus.req_tag[i*TW +: TW]   = t;
    bus.req_data[i*DW +: DW]  = d;
  endtask

  initial begin
    tests_run = 0;
    failed    = 0;
    for (int i = 0; i < N; i++) begin
      m_full[i] = 0; m_tag[i] = 0; m_data[i] = 0;
    end
    m_next = 0; m_cv = 0; m_ct = 0; m_cd = 0; m_cs = 0; m_busy = 0; m_conf = 0;

    rst = 1'b1; bus.rdy = 1'b1; bus.clear = 1'b0;
    bus.req_valid = '0; bus.req_tag = '0; bus.req_data = '0;

    // Reset then idle
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) step();
    check("idle_ready", bus.req_ready, 4'b1111);
    check("idle_tag", bus.cdb_tag, 4'd0);

    // Single result from requester 2
    present(2, 4'd5, 32'hDEADBEEF);
    step();
    bus.req_valid = '0;
    step();
    check("single_valid", bus.cdb_valid, 1'b1);
    check("single_tag", bus.cdb_tag, 4'd5);
    check("single_data", bus.cdb_data, 32'hDEADBEEF);
    check("single_src", bus.cdb_src, 2'd2);
    step();
    check("single_pulse", bus.cdb_valid, 1'b0);

    // Round-robin with all requesters busy (pointer currently at 3)
    for (int i = 0; i < N; i++) present(i, 4'(i + 1), 32'h1000 + i);
    for (int c = 0; c < 10; c++) step();
    bus.req_valid = '0;
    for (int c = 0; c < 5; c++) step();

    // Stall while the CDB holds tag 7
    present(0, 4'd7, 32'h77);
    step();
    bus.req_valid = '0;
    present(1, 4'd8, 32'h88);
    step();
    bus.req_valid = '0;
    check("stall_pre_tag", bus.cdb_tag, 4'd7);
    bus.rdy = 1'b0;
    present(2, 4'd3, 32'h33);
    for (int c = 0; c < 3; c++) step();
    check("stall_tag", bus.cdb_tag, 4'd7);
    check("stall_valid", bus.cdb_valid, 1'b1);
    bus.req_valid = '0;
    bus.rdy = 1'b1;
    step();
    check("stall_next_tag", bus.cdb_tag, 4'd8);
    step();
    check("stall_drained", bus.cdb_valid, 1'b0);

    // Flush with slots 0 and 3 full
    present(0, 4'd2, 32'hA0);
    present(3, 4'd6, 32'hA3);
    step();
    bus.req_valid = '0;
    bus.rdy = 1'b0;
    bus.clear = 1'b1;
    present(2, 4'd9, 32'hBAD);
    step();
    check("flush_valid", bus.cdb_valid, 1'b0);
    bus.req_valid = '0;
    bus.clear = 1'b0;
    bus.rdy = 1'b1;
    present(1, 4'd9, 32'h99);
    step();
    bus.req_valid = '0;
    step();
    check("flush_src", bus.cdb_src, 2'd1);
    check("flush_tag", bus.cdb_tag, 4'd9);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 149) == 0);
      bus.clear = ($urandom_range(0, 39) == 0);
      bus.rdy   = ($urandom_range(0, 4) != 0);
      for (int i = 0; i < N; i++) begin
        bus.req_valid[i]         = $urandom_range(0, 1) == 1;
        bus.req_tag[i*TW +: TW]  = 4'($urandom_range(0, 15));
        bus.req_data[i*DW +: DW] = $urandom;
      end
      step();
    end
    rst = 1'b0; bus.clear = 1'b0; bus.rdy = 1'b1; bus.req_valid = '0;
    for (int c = 0; c < 6; c++) step();

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
